erasure_locator_builder: RTL and testbench
==========================================

Name: erasure_locator_builder

Overview:
- Initiator on the erasure-table read interface of the RS(255,223) decoder.
- After a codeword is captured, it issues `send_erasure_positions`/`erasure_addr` requests to the erasure-position store and takes each returned locator X_j on `erasure_ready`/`erasure_data`.
- From the locators it builds the erasure locator polynomial Γ(x) = ∏(1 + X_j·x) in GF(2^8), primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D).
- Γ is then presented to the key-equation stage through a coefficient read port.

Parameters:
- MAX_ERASURES, 32, table depth and maximum Γ degree (2t).
- COEF_AW, 6, width of `coef_addr` and `erasure_count`.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  one-cycle pulse; begin a build using `erasure_count`.
- `erasure_count`  in  6  number of erasures N in the table (0..63 accepted on the port).
- `send_erasure_positions`  out  1  read request to the erasure store, one-cycle pulse.
- `erasure_addr`  out  8  table index for the request.
- `erasure_ready`  in  1  responder data-valid.
- `erasure_data`  in  8  locator X_j returned by the responder.
- `busy`  out  1  build in progress.
- `done`  out  1  Γ valid; held until the next accepted `start` or reset.
- `erasure_overflow`  out  1  N > MAX_ERASURES for the last build.
- `coef_addr`  in  6  Γ coefficient index.
- `coef_data`  out  8  Γ[`coef_addr`], combinational; 0 if `coef_addr` > MAX_ERASURES.

Behaviour:
- Reset values:
  - Outputs: `send_erasure_positions`=0, `erasure_addr`=0, `busy`=0, `done`=0, `erasure_overflow`=0.
  - Internal: Γ[0]=0x01, Γ[1..32]=0, state=IDLE.
  - Reset asserted mid-build aborts the build immediately; no further requests are issued.
- FSM states: IDLE, REQ, WAIT, UPDATE, DONE.
- IDLE/DONE:
  - On `start`: Γ reset to 1, j=0, `done`=0, `erasure_overflow`=0.
  - If N=0 → DONE.
  - If N>32 → `erasure_overflow`=1, Γ=1, → DONE.
  - Otherwise `busy`=1 → REQ.
- REQ:
  - Drive `send_erasure_positions`=1 and `erasure_addr`=j for exactly one cycle → WAIT.
- WAIT:
  - Hold until `erasure_ready`=1; no timeout.
  - On ready, latch X=`erasure_data`, set k=j+1 → UPDATE.
  - `erasure_ready` seen in any state other than WAIT is ignored.
- UPDATE: one coefficient per cycle, descending k.
  - Each cycle: Γ[k] ← Γ[k] ⊕ X·Γ[k−1].
  - If k=1: j←j+1; if j=N → DONE (`busy`=0, `done`=1), else → REQ.
  - Otherwise k←k−1.
  - Descending order guarantees Γ[k−1] is still the old value when Γ[k] is updated.
- X=0x00 is processed normally (a factor of 1, Γ unchanged); the block performs no filtering.
- `start` while `busy` is ignored. `start` in DONE restarts the build.
- Latency with a responder that asserts ready the cycle after a request:
  - Per erasure j: j+3 cycles.
  - `done` rises N(N+5)/2 + 1 cycles after the clock edge that samples `start` (N=0 → 1, N=32 → 593).
- Arithmetic: all additions are XOR. One shared GF(2^8) multiplier. Γ degree never exceeds N.

Decomposition:
- Shared package:
  - GF_POLY=8'h1D (reduction polynomial, implicit x^8).
  - MAX_ERASURES=32.
  - FSM state encoding constants.
- Sub-module `gf256_mult`: combinational 8×8 GF(2^8) multiplier using GF_POLY. The same block is reused by the syndrome and Chien stages.

Test Plan:
- Reset / idle:
  - Stimulus: assert `reset`, release, read `coef_addr` 0..32.
  - Response: Γ[0]=0x01, all others 0; all outputs 0.
- N=0:
  - Stimulus: `start` with N=0.
  - Response: `done`=1 one cycle later, no request issued, Γ=1.
- N=3, 1-cycle responder:
  - Stimulus: locators 0x02, 0x04, 0x08.
  - Response: addresses 0, 1, 2 requested once each; `done` at cycle 13.
  - Γ = {0x01, 0x0E, 0x38, 0x40}; Γ[4..32]=0.
- Slow responder:
  - Stimulus: N=2, X=0x02, 0x04, `erasure_ready` delayed 5 cycles.
  - Response: FSM holds in WAIT; Γ = {0x01, 0x06, 0x08}.
  - A spurious `erasure_ready` outside WAIT is ignored.
- Overflow:
  - Stimulus: `start` with N=33.
  - Response: `erasure_overflow`=1, `done`=1 next cycle, no requests, Γ=1.
- Abort and busy-start:
  - Stimulus: N=32 with `start` re-pulsed at cycle 50; then `reset` asserted at cycle 100.
  - Response: the `start` at cycle 50 is ignored.
  - Reset returns all state to reset values asynchronously, before the next clock edge.
  - A subsequent N=1 build with X=0x02 gives Γ = {0x01, 0x02}.

Source files
------------

// File: rtl/erasure_locator_builder_pkg.sv
// Shared constants and types for the erasure locator builder and its GF(2^8) helper.
package erasure_locator_builder_pkg;

  // Low byte of the field polynomial x^8+x^4+x^3+x^2+1; x^8 is implicit.
  localparam logic [7:0] GF_POLY = 8'h1D;

  // Table depth and maximum degree of the erasure locator polynomial.
  localparam int unsigned MAX_ERASURES = 32;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StUpdate,
    StDone
  } state_t;

endpackage

// File: rtl/gf256_mult.sv
// Combinational 8x8 multiplier over GF(2^8), reduced by GF_POLY.
module gf256_mult
  import erasure_locator_builder_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] p_o
);

  logic [7:0] acc;
  logic [7:0] sh;

  // Shift-and-add: accumulate a*x^i for each set bit of b, reducing a*x^i every step.
  always_comb begin
    acc = 8'h00;
    sh  = a_i;
    for (int i = 0; i < 8; i++) begin
      if (b_i[i]) begin
        acc = acc ^ sh;
      end
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? GF_POLY : 8'h00);
    end
    p_o = acc;
  end

endmodule

// File: rtl/erasure_locator_builder.sv
// Builds the erasure locator polynomial prod(1 + X_j*x) from locators fetched from the
// erasure-position store, and exposes its coefficients on a combinational read port.
module erasure_locator_builder #(
  parameter int unsigned MAX_ERASURES = erasure_locator_builder_pkg::MAX_ERASURES,
  parameter int unsigned COEF_AW      = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [COEF_AW-1:0] erasure_count,
  output logic               send_erasure_positions,
  output logic [7:0]         erasure_addr,
  input  logic               erasure_ready,
  input  logic [7:0]         erasure_data,
  output logic               busy,
  output logic               done,
  output logic               erasure_overflow,
  input  logic [COEF_AW-1:0] coef_addr,
  output logic [7:0]         coef_data
);

  import erasure_locator_builder_pkg::*;

  localparam int NumCoef = int'(MAX_ERASURES) + 1;

  state_t             state_q, state_d;
  logic [7:0]         gamma_q [NumCoef];
  logic [7:0]         gamma_d [NumCoef];
  logic [COEF_AW-1:0] j_q, j_d;   // index of the locator being folded in
  logic [COEF_AW-1:0] n_q, n_d;   // erasure count latched at start
  logic [COEF_AW-1:0] k_q, k_d;   // coefficient being updated, walks downwards
  logic [7:0]         x_q, x_d;   // current locator
  logic               ovf_q, ovf_d;
  logic [7:0]         gamma_prev;
  logic [7:0]         prod;

  // Select Gamma[k-1] as the multiplicand for the shared multiplier.
  always_comb begin
    gamma_prev = 8'h00;
    for (int i = 0; i < NumCoef - 1; i++) begin
      if (k_q == COEF_AW'(i + 1)) begin
        gamma_prev = gamma_q[i];
      end
    end
  end

  gf256_mult u_mult (
    .a_i (x_q),
    .b_i (gamma_prev),
    .p_o (prod)
  );

  // Next-state logic: build control and in-place polynomial update.
  always_comb begin
    state_d = state_q;
    gamma_d = gamma_q;
    j_d     = j_q;
    n_d     = n_q;
    k_d     = k_q;
    x_d     = x_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          for (int i = 0; i < NumCoef; i++) begin
            gamma_d[i] = 8'h00;
          end
          gamma_d[0] = 8'h01;
          j_d        = '0;
          n_d        = erasure_count;
          ovf_d      = 1'b0;
          if (erasure_count == '0) begin
            state_d = StDone;
          end else if (32'(erasure_count) > MAX_ERASURES) begin
            ovf_d   = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        state_d = StWait;
      end
      StWait: begin
        if (erasure_ready) begin
          x_d     = erasure_data;
          k_d     = j_q + COEF_AW'(1);
          state_d = StUpdate;
        end
      end
      StUpdate: begin
        // Descending k keeps Gamma[k-1] at its pre-multiply value.
        for (int i = 1; i < NumCoef; i++) begin
          if (k_q == COEF_AW'(i)) begin
            gamma_d[i] = gamma_q[i] ^ prod;
          end
        end
        if (k_q == COEF_AW'(1)) begin
          j_d     = j_q + COEF_AW'(1);
          state_d = ((j_q + COEF_AW'(1)) == n_q) ? StDone : StReq;
        end else begin
          k_d = k_q - COEF_AW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; reset aborts any build in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      for (int i = 0; i < NumCoef; i++) begin
        gamma_q[i] <= (i == 0) ? 8'h01 : 8'h00;
      end
      j_q   <= '0;
      n_q   <= '0;
      k_q   <= '0;
      x_q   <= 8'h00;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gamma_q <= gamma_d;
      j_q     <= j_d;
      n_q     <= n_d;
      k_q     <= k_d;
      x_q     <= x_d;
      ovf_q   <= ovf_d;
    end
  end

  // Status and request outputs decoded from the state register.
  always_comb begin
    send_erasure_positions = (state_q == StReq);
    erasure_addr           = (state_q == StReq) ? 8'(j_q) : 8'h00;
    busy                   = (state_q == StReq) || (state_q == StWait) ||
                             (state_q == StUpdate);
    done                   = (state_q == StDone);
    erasure_overflow       = ovf_q;
  end

  // Coefficient read port; indices beyond the maximum degree read as zero.
  always_comb begin
    coef_data = 8'h00;
    for (int i = 0; i < NumCoef; i++) begin
      if (coef_addr == COEF_AW'(i)) begin
        coef_data = gamma_q[i];
      end
    end
  end

endmodule

// File: tb/tb_erasure_locator_builder.sv
// Scoreboard bench: stimulus pushes expected requests and done latencies into queues,
// independent monitors pop and compare as the DUT presents them.
module tb_erasure_locator_builder;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [5:0] erasure_count = 6'd0;
  logic [5:0] coef_addr = 6'd0;
  logic       send_erasure_positions;
  logic [7:0] erasure_addr;
  logic       erasure_ready;
  logic [7:0] erasure_data;
  logic       busy;
  logic       done;
  logic       erasure_overflow;
  logic [7:0] coef_data;

  logic       resp_ready = 1'b0;
  logic [7:0] resp_data = 8'h00;
  logic       spur_ready = 1'b0;
  logic [7:0] spur_data = 8'h00;

  assign erasure_ready = resp_ready | spur_ready;
  assign erasure_data  = resp_ready ? resp_data : spur_data;

  int total = 0;
  int bad   = 0;

  logic [7:0] resp_q[$];
  int         exp_req_q[$];
  int         exp_lat_q[$];
  int         resp_delay = 1;
  logic [7:0] rd;
  bit         armed = 1'b0;
  int         cnt = 0;

  erasure_locator_builder dut (
    .clock                  (clock),
    .reset                  (reset),
    .start                  (start),
    .erasure_count          (erasure_count),
    .send_erasure_positions (send_erasure_positions),
    .erasure_addr           (erasure_addr),
    .erasure_ready          (erasure_ready),
    .erasure_data           (erasure_data),
    .busy                   (busy),
    .done                   (done),
    .erasure_overflow       (erasure_overflow),
    .coef_addr              (coef_addr),
    .coef_data              (coef_data)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Request monitor: every request pulse must match the next expected address.
  initial forever begin
    @(negedge clock);
    if (!reset && send_erasure_positions) begin
      if (exp_req_q.size() == 0) check("unexpected request", int'(erasure_addr), -1);
      else check("request addr", int'(erasure_addr), exp_req_q.pop_front());
    end
  end

  // Responder: answers each request with the next locator after resp_delay cycles.
  initial forever begin
    @(negedge clock);
    if (!reset && send_erasure_positions) begin
      rd = (resp_q.size() != 0) ? resp_q.pop_front() : 8'h00;
      repeat (resp_delay) @(posedge clock);
      #1 resp_ready = 1'b1;
      resp_data = rd;
      @(posedge clock);
      #1 resp_ready = 1'b0;
      resp_data = 8'h00;
    end
  end

  // Done monitor: counts clock edges from the edge that accepts start until done.
  initial forever begin
    @(negedge clock);
    if (reset) begin
      armed = 1'b0;
    end else begin
      if (armed) begin
        cnt++;
        if (done) begin
          armed = 1'b0;
          if (exp_lat_q.size() == 0) check("unexpected done", cnt, -1);
          else check("done latency", cnt, exp_lat_q.pop_front());
        end else if (cnt > 2000) begin
          armed = 1'b0;
          check("done timeout", cnt, -1);
        end
      end
      if (start && !busy) begin
        armed = 1'b1;
        cnt   = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start(input int n);
    @(posedge clock);
    #1 start = 1'b1;
    erasure_count = 6'(n);
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int c = 0;
    while (!done && c < 2000) begin
      @(negedge clock);
      c++;
    end
    check(name, int'(done), 1);
  endtask

  task automatic check_gamma(input string tag, input logic [7:0] c0, input logic [7:0] c1,
                             input logic [7:0] c2, input logic [7:0] c3);
    logic [7:0] e;
    for (int i = 0; i <= 32; i++) begin
      coef_addr = 6'(i);
      #1;
      case (i)
        0:       e = c0;
        1:       e = c1;
        2:       e = c2;
        3:       e = c3;
        default: e = 8'h00;
      endcase
      check($sformatf("%s gamma[%0d]", tag, i), int'(coef_data), int'(e));
    end
    coef_addr = 6'd0;
  endtask

  initial begin
    // Reset / idle
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("reset send", int'(send_erasure_positions), 0);
    check("reset addr", int'(erasure_addr), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset ovf", int'(erasure_overflow), 0);
    check_gamma("reset", 8'h01, 8'h00, 8'h00, 8'h00);
    coef_addr = 6'd40;
    #1 check("coef out of range", int'(coef_data), 0);
    coef_addr = 6'd0;

    // N=0: immediate done, no requests
    exp_lat_q.push_back(1);
    pulse_start(0);
    wait_done("n0 done");
    check_gamma("n0", 8'h01, 8'h00, 8'h00, 8'h00);

    // N=3, one-cycle responder
    resp_delay = 1;
    resp_q.push_back(8'h02); resp_q.push_back(8'h04); resp_q.push_back(8'h08);
    exp_req_q.push_back(0); exp_req_q.push_back(1); exp_req_q.push_back(2);
    exp_lat_q.push_back(13);
    pulse_start(3);
    wait_done("n3 done");
    check_gamma("n3", 8'h01, 8'h0E, 8'h38, 8'h40);

    // Field reduction and a zero locator: (1+0x80x)(1)(1+0x80x)
    resp_q.push_back(8'h80); resp_q.push_back(8'h00); resp_q.push_back(8'h80);
    exp_req_q.push_back(0); exp_req_q.push_back(1); exp_req_q.push_back(2);
    exp_lat_q.push_back(13);
    pulse_start(3);
    wait_done("x80 done");
    check_gamma("x80", 8'h01, 8'h00, 8'h13, 8'h00);

    // Overflow
    exp_lat_q.push_back(1);
    pulse_start(33);
    wait_done("ovf done");
    check("ovf flag", int'(erasure_overflow), 1);
    check_gamma("ovf", 8'h01, 8'h00, 8'h00, 8'h00);

    // Slow responder, with spurious ready around the start while not in WAIT
    @(posedge clock);
    #1 spur_ready = 1'b1;
    spur_data = 8'h55;
    resp_delay = 5;
    resp_q.push_back(8'h02); resp_q.push_back(8'h04);
    exp_req_q.push_back(0); exp_req_q.push_back(1);
    exp_lat_q.push_back(16);
    pulse_start(2);
    @(posedge clock);
    #1 spur_ready = 1'b0;
    spur_data = 8'h00;
    wait_done("slow done");
    check("slow ovf cleared", int'(erasure_overflow), 0);
    check_gamma("slow", 8'h01, 8'h06, 8'h08, 8'h00);

    // Abort: N=32, busy start ignored, reset mid-build
    resp_delay = 1;
    for (int j = 0; j < 32; j++) resp_q.push_back(8'(j * 7 + 3));
    for (int j = 0; j < 12; j++) exp_req_q.push_back(j);
    pulse_start(32);
    repeat (49) @(posedge clock);
    #1 start = 1'b1;
    erasure_count = 6'd5;
    @(posedge clock);
    #1 start = 1'b0;
    check("busy at restart", int'(busy), 1);
    repeat (45) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("abort busy", int'(busy), 0);
    check("abort send", int'(send_erasure_positions), 0);
    check("abort done", int'(done), 0);
    check("abort addr", int'(erasure_addr), 0);
    check_gamma("abort", 8'h01, 8'h00, 8'h00, 8'h00);
    resp_q.delete();
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("abort requests left", exp_req_q.size(), 0);

    // Build after abort
    resp_q.push_back(8'h02);
    exp_req_q.push_back(0);
    exp_lat_q.push_back(4);
    pulse_start(1);
    wait_done("post-abort done");
    check_gamma("post-abort", 8'h01, 8'h02, 8'h00, 8'h00);

    repeat (3) @(negedge clock);
    check("pending requests", exp_req_q.size(), 0);
    check("pending dones", exp_lat_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
